// File: rtl/char_glyph_blitter.sv
// Renders one 8x8 font glyph into the frame buffer, one pixel write per DRAW cycle.
// Latency: fixed 81 cycles from request transfer to the done pulse (10 cycles per row + DONE).
// Backpressure: req_ready is high only in IDLE; a request waits until the previous glyph has finished.
module char_glyph_blitter #(
   parameter int H_RES       = 1280,
   parameter int V_RES       = 1024,
   parameter bit TRANSPARENT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [11:0] req_x,
   input  logic [11:0] req_y,
   input  logic [5:0]  req_char,
   input  logic [11:0] req_color,
   output logic [8:0]  font_addr,
   input  logic [7:0]  font_data,
   output logic        fb_we,
   output logic [11:0] fb_x,
   output logic [11:0] fb_y,
   output logic [11:0] fb_color,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LATCH = 3'd2,
      S_DRAW  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Request fields captured at transfer; the live inputs are ignored while busy.
   logic [11:0] x_r;
   logic [11:0] y_r;
   logic [5:0]  char_r;
   logic [11:0] color_r;

   // Walk position inside the glyph and the current row's bitmap.
   logic [2:0]  row;
   logic [2:0]  col;
   logic [7:0]  row_bits;

   logic        transfer;
   logic        last_col;
   logic        last_row;
   logic        in_draw;
   logic [12:0] sum_x;
   logic [12:0] sum_y;
   logic        pix_set;
   logic        in_bounds;

   assign transfer = (state == S_IDLE) && req_valid;
   assign last_col = (col == 3'd7);
   assign last_row = (row == 3'd7);
   assign in_draw  = (state == S_DRAW);

   // Pixel coordinates are formed one bit wider so a glyph hanging past
   // column/row 4095 can still be recognised as off-screen.
   assign sum_x     = {1'b0, x_r} + {10'd0, col};
   assign sum_y     = {1'b0, y_r} + {10'd0, row};
   assign pix_set   = row_bits[3'd7 - col];
   assign in_bounds = (sum_x < 13'(H_RES)) && (sum_y < 13'(V_RES));

   // State register; reset always lands in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode: one ROM fetch and one latch cycle ahead of every 8-pixel row.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: state_nxt = S_LATCH;
         S_LATCH: state_nxt = S_DRAW;
         S_DRAW: begin
            if (last_col) begin
               state_nxt = last_row ? S_DONE : S_FETCH;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status and frame-buffer outputs; coordinates are shown only while drawing.
   always_comb begin
      req_ready = (state == S_IDLE);
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      fb_we     = in_draw && in_bounds && (pix_set || !TRANSPARENT);
      fb_x      = in_draw ? sum_x[11:0] : 12'd0;
      fb_y      = in_draw ? sum_y[11:0] : 12'd0;
      fb_color  = (in_draw && pix_set) ? color_r : 12'h000;
   end

   // Capture the request at transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_r     <= 12'd0;
         y_r     <= 12'd0;
         char_r  <= 6'd0;
         color_r <= 12'd0;
      end else if (transfer) begin
         x_r     <= req_x;
         y_r     <= req_y;
         char_r  <= req_char;
         color_r <= req_color;
      end
   end

   // Row/column walk: col sweeps 0..7 in DRAW, row advances on the last column.
   always_ff @(posedge clk) begin
      if (reset) begin
         row <= 3'd0;
         col <= 3'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (transfer) begin
                  row <= 3'd0;
                  col <= 3'd0;
               end
            end
            S_LATCH: col <= 3'd0;
            S_DRAW: begin
               col <= col + 3'd1;
               if (last_col && !last_row) begin
                  row <= row + 3'd1;
               end
            end
            S_DONE: begin
               row <= 3'd0;
               col <= 3'd0;
            end
            default: ;
         endcase
      end
   end

   // ROM address is loaded on entry to FETCH so it is stable for the whole FETCH
   // cycle, and simply holds afterwards. The row-0 address comes straight from the
   // request because char_r is only written on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         font_addr <= 9'd0;
      end else if (transfer) begin
         font_addr <= {req_char, 3'd0};
      end else if (in_draw && last_col && !last_row) begin
         font_addr <= {char_r, row + 3'd1};
      end
   end

   // The ROM answers the cycle after FETCH; capture that row in LATCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_bits <= 8'd0;
      end else if (state == S_LATCH) begin
         row_bits <= font_data;
      end
   end

endmodule

// File: tb/tb_char_glyph_blitter.sv
// Bench for char_glyph_blitter: two instances (transparent and opaque) share stimulus.
// Each glyph is checked cycle by cycle against expectations derived from the glyph bitmap.
// Inputs are driven 1 time unit after the rising edge and outputs sampled on the falling edge.
module tb_char_glyph_blitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [11:0] req_x;
   logic [11:0] req_y;
   logic [5:0]  req_char;
   logic [11:0] req_color;

   logic        ready1, ready0;
   logic [8:0]  fa1, fa0;
   logic [7:0]  fd1, fd0;
   logic        we1, we0;
   logic [11:0] fx1, fy1, fc1, fx0, fy0, fc0;
   logic        busy1, busy0, done1, done0;

   logic [7:0]  rom [512];

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   // Synchronous font ROM, one read port per instance.
   always @(posedge clk) begin
      fd1 <= rom[fa1];
      fd0 <= rom[fa0];
   end

   char_glyph_blitter #(.H_RES(1280), .V_RES(1024), .TRANSPARENT(1'b1)) u_t1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
      .req_x(req_x), .req_y(req_y), .req_char(req_char), .req_color(req_color),
      .font_addr(fa1), .font_data(fd1), .fb_we(we1), .fb_x(fx1), .fb_y(fy1),
      .fb_color(fc1), .busy(busy1), .done(done1)
   );

   char_glyph_blitter #(.H_RES(1280), .V_RES(1024), .TRANSPARENT(1'b0)) u_t0 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
      .req_x(req_x), .req_y(req_y), .req_char(req_char), .req_color(req_color),
      .font_addr(fa0), .font_data(fd0), .fb_we(we0), .fb_x(fx0), .fb_y(fy0),
      .fb_color(fc0), .busy(busy0), .done(done0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Idle cycles with no request: blitter must sit ready and silent.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         @(negedge clk);
         check("idle_ready", 32'(ready1 & ready0), 32'd1);
         check("idle_busy", 32'(busy1 | busy0), 32'd0);
         check("idle_we", 32'(we1 | we0), 32'd0);
         check("idle_done", 32'(done1 | done0), 32'd0);
      end
   endtask

   // Issue one request and check all 81 cycles up to done. Inputs are scrambled
   // while busy; hold keeps req_valid high throughout. abort_at > 0 pulses reset
   // in that cycle and then checks the blitter stays quiet.
   task automatic do_glyph(input logic [11:0] x, input logic [11:0] y, input logic [5:0] ch,
                           input logic [11:0] color, input bit hold, input int abort_at,
                           output int w1, output int w0);
      int        r, p, c, sx, sy;
      bit        inb, bitv, aborted;
      logic [8:0] a;
      logic [7:0] rb;
      w1 = 0;
      w0 = 0;
      aborted = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_x     = x;
      req_y     = y;
      req_char  = ch;
      req_color = color;
      @(negedge clk);
      check("xfer_ready", 32'(ready1 & ready0), 32'd1);
      for (int k = 1; k <= 81; k++) begin
         @(posedge clk); #1;
         req_x     = 12'($urandom);
         req_y     = 12'($urandom);
         req_char  = 6'($urandom);
         req_color = 12'($urandom);
         req_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
         if (k == abort_at) reset = 1'b1;
         @(negedge clk);
         if (we1) w1++;
         if (we0) w0++;
         check("busy", 32'(busy1 & busy0), 32'd1);
         check("ready_low", 32'(ready1 | ready0), 32'd0);
         check("done", 32'(done1), (k == 81) ? 32'd1 : 32'd0);
         check("done_t0", 32'(done0), (k == 81) ? 32'd1 : 32'd0);
         if (k <= 80) begin
            r = (k - 1) / 10;
            p = (k - 1) % 10;
            a = {ch, 3'(r)};
            if (p == 0) begin
               check("font_addr", 32'(fa1), 32'(a));
               check("font_addr_t0", 32'(fa0), 32'(a));
            end
            if (p >= 2) begin
               c    = p - 2;
               rb   = rom[a];
               bitv = rb[7 - c];
               sx   = int'(x) + c;
               sy   = int'(y) + r;
               inb  = (sx < 1280) && (sy < 1024);
               check("we_t1", 32'(we1), 32'(inb && bitv));
               check("we_t0", 32'(we0), 32'(inb));
               check("fb_x", 32'(fx1), 32'(sx % 4096));
               check("fb_y", 32'(fy1), 32'(sy % 4096));
               check("fb_color", 32'(fc1), bitv ? 32'(color) : 32'd0);
               check("fb_x_t0", 32'(fx0), 32'(sx % 4096));
               check("fb_color_t0", 32'(fc0), bitv ? 32'(color) : 32'd0);
            end else begin
               check("we_nodraw", 32'(we1 | we0), 32'd0);
            end
         end else begin
            check("we_done", 32'(we1 | we0), 32'd0);
         end
         if (k == abort_at) begin
            aborted = 1'b1;
            break;
         end
      end
      if (aborted) begin
         for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            reset     = 1'b0;
            req_valid = 1'b0;
            @(negedge clk);
            check("abort_busy", 32'(busy1 | busy0), 32'd0);
            check("abort_we", 32'(we1 | we0), 32'd0);
            check("abort_done", 32'(done1 | done0), 32'd0);
            check("abort_ready", 32'(ready1 & ready0), 32'd1);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w1, w0;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_x     = 12'd0;
      req_y     = 12'd0;
      req_char  = 6'd0;
      req_color = 12'd0;
      for (int i = 0; i < 512; i++) rom[i] = 8'($urandom);
      for (int r = 0; r < 8; r++) begin
         rom[13 * 8 + r] = 8'h81;
         rom[5 * 8 + r]  = 8'hF0;
         rom[20 * 8 + r] = 8'hFF;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(ready1 & ready0), 32'd1);
      check("rst_busy", 32'(busy1 | busy0), 32'd0);
      check("rst_done", 32'(done1 | done0), 32'd0);
      check("rst_we", 32'(we1 | we0), 32'd0);
      check("rst_fb_x", 32'(fx1), 32'd0);
      check("rst_fb_y", 32'(fy1), 32'd0);
      check("rst_fb_color", 32'(fc1), 32'd0);
      check("rst_font_addr", 32'(fa1), 32'd0);

      // Single glyph with two set columns.
      do_glyph(12'd1120, 12'd100, 6'd13, 12'hFFF, 1'b0, 0, w1, w0);
      check("single_writes_t1", 32'(w1), 32'd16);
      check("single_writes_t0", 32'(w0), 32'd64);
      idle(3);

      // Half-set rows: opaque instance writes every pixel.
      do_glyph(12'd1135, 12'd0, 6'd5, 12'h5A3, 1'b0, 0, w1, w0);
      check("transp_writes_t1", 32'(w1), 32'd32);
      check("transp_writes_t0", 32'(w0), 32'd64);
      idle(2);

      // Bottom-right corner clipping.
      do_glyph(12'd1276, 12'd1020, 6'd20, 12'h0F0, 1'b0, 0, w1, w0);
      check("clip_writes_t1", 32'(w1), 32'd16);
      check("clip_writes_t0", 32'(w0), 32'd16);
      idle(2);

      // Back-to-back with req_valid held high.
      do_glyph(12'd200, 12'd300, 6'd13, 12'h123, 1'b1, 0, w1, w0);
      do_glyph(12'd208, 12'd300, 6'd5, 12'h456, 1'b0, 0, w1, w0);
      check("b2b_writes_t1", 32'(w1), 32'd32);
      idle(2);

      // Reset in the middle of a glyph, then a normal glyph.
      do_glyph(12'd400, 12'd400, 6'd20, 12'hABC, 1'b0, 40, w1, w0);
      do_glyph(12'd400, 12'd400, 6'd20, 12'hABC, 1'b0, 0, w1, w0);
      check("post_abort_writes", 32'(w1), 32'd64);
      idle(1);

      // Highest glyph code; also fully off-screen glyphs.
      do_glyph(12'd0, 12'd1016, 6'd63, 12'h777, 1'b0, 0, w1, w0);
      idle(1);
      do_glyph(12'd1280, 12'd10, 6'd20, 12'h777, 1'b0, 0, w1, w0);
      check("offscreen_x_t0", 32'(w0), 32'd0);
      do_glyph(12'd4093, 12'd4090, 6'd20, 12'h777, 1'b0, 0, w1, w0);
      check("offscreen_wrap_t0", 32'(w0), 32'd0);

      // Randomized glyphs around the screen edges, with random gaps.
      for (int n = 0; n < 12; n++) begin
         idle($urandom_range(0, 2));
         do_glyph(12'($urandom_range(1180, 1300)), 12'($urandom_range(950, 1050)),
                  6'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), 0, w1, w0);
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/char_glyph_blitter.md
Name: char_glyph_blitter

Overview:
- Consumer side of the on/off text-indicator interface: takes a (horizontal coordinate, 6-bit char code) draw request and renders that glyph into the frame buffer.
- Fetches 8 glyph rows from the shared synchronous font ROM, walks 8 pixels per row, and issues one frame-buffer write per in-bounds pixel.
- Sits between the status-text generators and the frame-buffer write port.

Parameters:
- H_RES, 1280, visible width in pixels; x >= H_RES is clipped.
- V_RES, 1024, visible height in pixels; y >= V_RES is clipped.
- TRANSPARENT, 1, 1 = write only set glyph bits; 0 = also write clear bits with colour 12'h000.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  draw request present.
- req_ready  out  1  blitter can accept a request.
- req_x  in  12  left pixel column of glyph.
- req_y  in  12  top pixel row of glyph.
- req_char  in  6  glyph code, 0..63.
- req_color  in  12  foreground colour, RGB 4:4:4.
- font_addr  out  9  font ROM address = {char, row[2:0]}.
- font_data  in  8  ROM row bits, valid the cycle after font_addr; bit 7 = leftmost pixel.
- fb_we  out  1  frame-buffer write strobe.
- fb_x  out  12  write column.
- fb_y  out  12  write row.
- fb_color  out  12  write colour.
- busy  out  1  request in progress.
- done  out  1  one-cycle pulse when a glyph finishes.

Behaviour:
Reset:
- State IDLE. req_ready=1 from the first cycle after reset.
- busy=0, done=0, fb_we=0, fb_x=fb_y=fb_color=0, font_addr=0.
- All internal row/col counters are 0.

Handshake:
- Transfer occurs on a cycle with req_valid && req_ready.
- req_ready=1 only in IDLE.
- req_x, req_y, req_char and req_color are latched at transfer. Later input changes are ignored until the next transfer.

States:
- IDLE: wait for a transfer, then go to FETCH with row=0.
- FETCH (1 cycle): font_addr = {char_r, row}. Go to LATCH.
- LATCH (1 cycle): register font_data into row_bits. Go to DRAW with col=0.
- DRAW (8 cycles, col=0..7):
  - Pixel is set when row_bits[7-col]=1.
  - fb_x = x_r+col and fb_y = y_r+row, both valid in the same cycle as the state.
  - fb_color = colour_r for a set bit, 12'h000 otherwise.
  - fb_we = in_bounds && (set || !TRANSPARENT).
  - At col=7: if row=7 go to DONE, else row++ and go to FETCH.
- DONE (1 cycle): done=1, then return to IDLE.

Outputs by state:
- busy=1 in every state except IDLE.
- fb_we=0 outside DRAW.
- font_addr holds its last value outside FETCH.

Timing:
- Transfer at cycle T: first FETCH at T+1, first DRAW at T+3.
- Each row takes 10 cycles. Last DRAW is at T+80, done at T+81, req_ready=1 again at T+82.
- Fixed 81-cycle latency regardless of clipping or glyph content.

Arithmetic and clipping:
- Sums are computed 13 bits wide.
- in_bounds = (x_r+col < H_RES) && (y_r+row < V_RES).
- Out-of-bounds pixels still consume their DRAW cycle with fb_we=0. fb_x/fb_y then show the low 12 bits of the sum.
- A glyph that is entirely off-screen produces zero writes and still raises done.

Boundary cases:
- req_valid held high across done: the next transfer happens in the IDLE cycle at T+82. Back-to-back throughput is one glyph per 82 cycles.
- req_valid asserted during busy: no transfer and no effect.
- reset mid-glyph: the very next cycle is IDLE with all reset values. No further fb_we and no done pulse for the aborted glyph.
- req_char=63: font_addr = 9'h1F8..9'h1FF with no wrap.

Test Plan:
- Single glyph: reset, then request x=1120, y=100, char=13, colour=12'hFFF, ROM row r = 8'h81 for all rows. Required: 16 writes at (1120,100+r) and (1127,100+r); done at T+81; req_ready=0 from T+1 to T+81.
- Transparency: TRANSPARENT=0, char=5, x=1135, y=0, ROM=8'hF0. Required: 64 writes; cols 0-3 colour req_color, cols 4-7 colour 12'h000; done at T+81.
- Clipping: x=1276, y=1020, ROM=8'hFF. Required: writes only for cols 0-3 × rows 0-3 (16 writes), no x>=1280 or y>=1024 write; done at T+81.
- Back-to-back: req_valid held high with char 13 then char 5. Required: second transfer exactly at T+82; font_addr for row 0 of the second glyph = 9'h028.
- Reset mid-operation: assert reset at T+40 for 1 cycle. Required: fb_we=0 and busy=0 from T+41; no done pulse; req_ready=1; a new request then completes normally in 81 cycles.
- Input stability: change req_x/req_char during busy. Required: the write coordinates and font addresses use only the values latched at transfer.
